// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, default datapath width and execute-stage
// state encoding. The op code enum is also consumed by the ALU decoder.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_ctrl_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } exec_state_e;

  function automatic logic isShiftOp(alu_ctrl_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: shift engine for the execute stage.
// Default build: one bit per cycle. A start latches the operand, op and
// amount; each active cycle shifts by one and decrements the counter, and
// done pulses on the cycle whose edge produces the final value.
// With ALU_EXEC_FAST_SHIFT_EN defined: a combinational barrel shifter on the
// live inputs, done never asserts and no state is kept.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN    = ALU_XLEN,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_active,
  input  logic               i_hold,
  input  logic               i_abort,
  input  alu_ctrl_e          i_op,
  input  logic [XLEN-1:0]    i_value,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_done,
  output logic [XLEN-1:0]    o_result
);

`ifdef ALU_EXEC_FAST_SHIFT_EN

  logic w_unused;

  assign w_unused = ^{clk, rst_n, i_start, i_active, i_hold, i_abort};
  assign o_done   = 1'b0;

  // Full shift in one step; SRA replicates the sign bit
  always_comb begin
    o_result = i_value;
    case (i_op)
      ALU_SLL: o_result = i_value << i_shamt;
      ALU_SRL: o_result = i_value >> i_shamt;
      ALU_SRA: o_result = XLEN'($signed(i_value) >>> i_shamt);
      default: o_result = i_value;
    endcase
  end

`else

  logic [XLEN-1:0]    r_value;
  logic [SHAMT_W-1:0] r_count;
  alu_ctrl_e          r_op;
  logic [XLEN-1:0]    w_next;
  logic               w_last;
  logic               w_step;

  function automatic logic [XLEN-1:0] shiftOnce(alu_ctrl_e op, logic [XLEN-1:0] v);
    case (op)
      ALU_SLL: return {v[XLEN-2:0], 1'b0};
      ALU_SRL: return {1'b0, v[XLEN-1:1]};
      ALU_SRA: return {v[XLEN-1], v[XLEN-1:1]};
      default: return v;
    endcase
  endfunction

  assign w_next   = shiftOnce(r_op, r_value);
  assign w_last   = (r_count == SHAMT_W'(1));
  // The last step is withheld while the output register cannot take a result
  assign w_step   = i_active & ~i_abort & ~(w_last & i_hold);
  assign o_done   = w_step & w_last;
  assign o_result = w_next;

  // Shift register and counter: load on start, one-bit step while active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_count <= '0;
      r_op    <= ALU_ADD;
    end else if (i_abort) begin
      r_count <= '0;
    end else if (i_start) begin
      r_value <= i_value;
      r_count <= i_shamt;
      r_op    <= i_op;
    end else if (w_step) begin
      r_value <= w_next;
      r_count <= r_count - SHAMT_W'(1);
    end
  end

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result and zero flag,
// valid/ready on both sides so shifts can stall the pipeline.
// Optional macro ALU_EXEC_FAST_SHIFT_EN selects a single-cycle barrel
// shifter; otherwise shifts run one bit per cycle under the SHIFT state.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = ALU_XLEN,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            busy
);

  exec_state_e        r_state;
  exec_state_e        w_stateNext;
  logic               r_outValid;
  logic [XLEN-1:0]    r_result;
  logic               r_zero;

  alu_ctrl_e          w_op;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_outFree;
  logic               w_fireIn;
  logic               w_startShift;
  logic               w_loadSingle;
  logic               w_shiftDone;
  logic               w_load;
  logic               w_lt;
  logic [XLEN-1:0]    w_shiftResult;
  logic [XLEN-1:0]    w_singleResult;
  logic [XLEN-1:0]    w_loadValue;

  assign w_op      = alu_ctrl_e'(alu_control);
  assign w_shamt   = src_b[SHAMT_W-1:0];
  assign w_outFree = ~r_outValid | out_ready;
  // Flush blocks acceptance so a killed cycle cannot start new work
  assign in_ready  = (r_state == IDLE) & w_outFree & ~flush;
  assign w_fireIn  = in_valid & in_ready;
  assign w_lt      = $signed(src_a) < $signed(src_b);

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign w_startShift = 1'b0;
  assign busy         = 1'b0;
`else
  logic w_shamtZero;
  assign w_shamtZero  = (w_shamt == '0);
  assign w_startShift = w_fireIn & isShiftOp(w_op) & ~w_shamtZero;
  assign busy         = (r_state == SHIFT);
`endif

  assign w_loadSingle = w_fireIn & ~w_startShift;
  assign w_load       = w_loadSingle | w_shiftDone;
  assign w_loadValue  = w_shiftDone ? w_shiftResult : w_singleResult;

  alu_shift_iter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_startShift),
    .i_active (r_state == SHIFT),
    .i_hold   (~w_outFree),
    .i_abort  (flush),
    .i_op     (w_op),
    .i_value  (src_a),
    .i_shamt  (w_shamt),
    .o_done   (w_shiftDone),
    .o_result (w_shiftResult)
  );

  // Single-cycle result; a zero-amount shift simply passes operand A through
  always_comb begin
    w_singleResult = '0;
    case (w_op)
      ALU_ADD: w_singleResult = src_a + src_b;
      ALU_SUB: w_singleResult = src_a - src_b;
      ALU_AND: w_singleResult = src_a & src_b;
      ALU_OR:  w_singleResult = src_a | src_b;
      ALU_SLT: w_singleResult = {{(XLEN-1){1'b0}}, w_lt};
`ifdef ALU_EXEC_FAST_SHIFT_EN
      ALU_SLL, ALU_SRL, ALU_SRA: w_singleResult = w_shiftResult;
`else
      ALU_SLL, ALU_SRL, ALU_SRA: w_singleResult = src_a;
`endif
      default: w_singleResult = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: enter SHIFT on a nonzero shift, leave on completion or flush
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_startShift) w_stateNext = SHIFT;
      SHIFT:   if (flush || w_shiftDone) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Output register: flush kills, a new result loads, otherwise drain on ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_result   <= w_loadValue;
      r_zero     <= (w_loadValue == '0);
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid  = r_outValid;
  assign alu_result = r_result;
  assign zero       = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed, table-driven bench for alu_exec_unit
// (default iterative-shift build).
module tb_alu_exec_unit;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;
  localparam int NV = 13;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    logic        expZero;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        zero;
  logic        busy;

  int   checks;
  int   errors;
  vec_t vecs[NV];

  alu_exec_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_result  (alu_result),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic rdy, input logic fl);
    in_valid    = v;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    out_ready   = rdy;
    flush       = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Launch a nonzero shift, count busy cycles, then check the result
  task automatic runShift(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int expCycles, input logic [31:0] expRes);
    int cycles;
    int readyBad;
    cycles   = 0;
    readyBad = 0;
    applyStimulus(1'b1, op, a, b, 1'b1, 1'b0);
    #1 checkOutput({name, "_accept_ready"}, {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      cycles++;
      if (in_ready) readyBad++;
      @(negedge clk);
    end
    checkOutput({name, "_busy_cycles"}, cycles, expCycles);
    checkOutput({name, "_ready_while_busy"}, readyBad, 0);
    checkOutput({name, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({name, "_result"}, alu_result, expRes);
    @(negedge clk);
    checkOutput({name, "_drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int ovSeen;
    checks = 0;
    errors = 0;

    vecs[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[1]  = '{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
    vecs[2]  = '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[3]  = '{OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[4]  = '{OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
    vecs[5]  = '{OP_OR,  32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1'b0};
    vecs[6]  = '{OP_SLL, 32'h00000001, 32'h00000020, 32'h00000001, 1'b0};
    vecs[7]  = '{OP_SRA, 32'h80000000, 32'hFFFFFFE0, 32'h80000000, 1'b0};
    vecs[8]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[9]  = '{OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{OP_AND, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1};
    vecs[11] = '{OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
    vecs[12] = '{OP_SRL, 32'h80000000, 32'h00000020, 32'h80000000, 1'b0};

    // Reset values
    rst_n = 1'b0;
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    #2;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_result", alu_result, 32'h0);
    checkOutput("rst_zero", {31'b0, zero}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops at one per cycle
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      #1 checkOutput($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("vec%0d_result", i), alu_result, vecs[i].expResult);
      checkOutput($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].expZero});
    end
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("table_drained", {31'b0, out_valid}, 32'd0);

    // Iterative shifts
    runShift("sra31", OP_SRA, 32'h80000000, 32'h0000001F, 31, 32'hFFFFFFFF);
    runShift("srl4", OP_SRL, 32'h000000F0, 32'h00000004, 4, 32'h0000000F);
    runShift("sll1", OP_SLL, 32'h00000001, 32'hFFFFFFE1, 1, 32'h00000002);

    // Backpressure: pending OR result holds, second op waits
    applyStimulus(1'b1, OP_OR, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0);
    #1 checkOutput("bp_first_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, OP_ADD, 32'd10, 32'd20, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("bp_hold%0d_valid", k), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("bp_hold%0d_result", k), alu_result, 32'h000000FF);
      checkOutput($sformatf("bp_hold%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    checkOutput("bp_second_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bp_second_result", alu_result, 32'd30);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);

    // Flush during SRL by 10, in its third cycle
    applyStimulus(1'b1, OP_SRL, 32'hFFFF0000, 32'd10, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, OP_ADD, 32'd7, 32'd7, 1'b1, 1'b1);
    #1 checkOutput("flush_shift_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
    ovSeen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) ovSeen++;
    end
    checkOutput("flush_no_result", ovSeen, 0);

    // Flush in IDLE outranks a simultaneous request
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, 1'b1);
    #1 checkOutput("flush_idle_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_idle_not_accepted", {31'b0, out_valid}, 32'd0);

    applyStimulus(1'b1, OP_ADD, 32'd2, 32'd3, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("post_flush_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("post_flush_result", alu_result, 32'd5);
    @(negedge clk);

    // Asynchronous reset mid-shift
    applyStimulus(1'b1, OP_SLL, 32'h00000001, 32'd20, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async_rst_result", alu_result, 32'h0);
    checkOutput("async_rst_zero", {31'b0, zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, OP_AND, 32'h0000F0F0, 32'h0000FF00, 1'b1, 1'b0);
    #1 checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("post_rst_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("post_rst_result", alu_result, 32'h0000F000);
    checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("post_rst_drained", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 3-bit ALUControl from the ALU decoder together with two 32-bit operands.
- Produces a registered result and a Zero flag for writeback and branch resolution.
- Single-cycle for arithmetic/logic/compare; shifts are iterative, 1 bit/cycle, under a small FSM.
- valid/ready handshake on both sides so the stage can stall the pipeline during shifts.

Parameters:
- XLEN, 32, operand/result width (power of two, >= 8).
- SHAMT_W, $clog2(XLEN), width of shift amount taken from SrcB[SHAMT_W-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and ALUControl valid.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_control  input  3  op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SLT, 110 SRL, 111 SRA.
- src_a  input  XLEN  operand A.
- src_b  input  XLEN  operand B; low SHAMT_W bits are the shift amount for shifts.
- flush  input  1  synchronous kill of in-flight and pending result.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts result.
- alu_result  output  XLEN  registered result.
- zero  output  1  registered (alu_result == 0).
- busy  output  1  FSM in SHIFT state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, alu_result=0, zero=0, busy=0, shift counter=0.
- Accept: fire_in = in_valid & in_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready). Combinational; it does not depend on in_valid.
- Output handshake: the result holds stable while out_valid & !out_ready. out_valid clears on out_ready unless a new result loads the same cycle.
- States:
  - IDLE -> IDLE on a single-cycle op (ADD/SUB/AND/OR/SLT) or a shift with shamt=0; the result loads at the next edge, so latency is 1 cycle.
  - IDLE -> SHIFT on a shift with shamt != 0. Operand A and the op are latched, and count=shamt.
  - SHIFT: each cycle the latched value shifts by 1 (SLL: zero fill left; SRL: zero fill right; SRA: sign fill right) and count decrements.
  - SHIFT -> IDLE when count reaches 1. The final value loads into alu_result with out_valid=1. Total latency = shamt cycles from acceptance, min 1.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN; no carry/overflow outputs.
- SLT: signed compare, result = {XLEN-1 zeros, (a<b signed)}.
- AND/OR are bitwise.
- Shift amount uses only src_b[SHAMT_W-1:0]; upper bits are ignored.
- zero is computed from the value being loaded into alu_result and registered with it.
- Boundary conditions:
  - Back-to-back single-cycle ops with out_ready=1 sustain 1 op/cycle.
  - out_ready=0 with out_valid=1: in_ready=0 and nothing is accepted.
  - A SHIFT completing while the output is full is impossible, because entry to SHIFT requires the output to drain by completion. The FSM waits in SHIFT with count==1 until !out_valid | out_ready.
  - flush: state->IDLE and out_valid->0 at the next edge; an in_valid in the same cycle is not accepted (in_ready forced 0 while flush=1). flush has priority over all other events.
  - Asynchronous reset mid-shift aborts immediately with no partial result.

Optional Feature:
- ALU_EXEC_FAST_SHIFT_EN defined: shifts use a single-cycle barrel shifter. The SHIFT state is never entered, all ops have 1-cycle latency, and busy is tied 0.
- Undefined: iterative shifter as described above.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package alu_pkg:
  - enum alu_ctrl_e for the eight 3-bit codes (also used by the ALU decoder).
  - XLEN default constant.
  - exec state enum {IDLE, SHIFT}.
- One sub-module: alu_shift_iter, holding the shift register, counter and fill logic. It exposes start/done, op, value and shamt. Under the macro it is replaced by a combinational barrel shift inside it.

Test Plan:
- ADD 0x7FFFFFFF+1, then SUB 5-5, out_ready=1 -> results 0x80000000 (zero=0) then 0x00000000 (zero=1). out_valid is 1 for each cycle after acceptance, at 1 op/cycle.
- SLT with a=0xFFFFFFFF (-1), b=1 -> result 1. With a=1, b=0xFFFFFFFF -> result 0.
- SRA a=0x80000000, b=0x0000001F (iterative) -> busy for 31 cycles, result 0xFFFFFFFF at cycle 31, in_ready=0 throughout. SLL a=1, b=0x20 (shamt 0) -> result 1 in 1 cycle.
- Backpressure: an OR result is pending with out_ready=0 for 4 cycles -> alu_result stable, in_ready=0, a second in_valid is not accepted. Release -> the second op is accepted the same cycle.
- flush at cycle 3 of SRL shamt=10 -> out_valid never asserts, state=IDLE next cycle. The next ADD 2+3 -> 5 with 1-cycle latency.
- rst_n pulsed low asynchronously mid-shift (between clock edges) -> outputs zeroed immediately. After release, AND 0xF0F0&0xFF00 -> 0xF000.
